team_06_pwm_dac: RTL and testbench



---
 rtl/team_06_pwm_pkg.sv | 13 +
 rtl/team_06_pwm_counter.sv | 20 ++
 rtl/team_06_pwm_dac.sv | 104 ++++++++++
 tb/tb_team_06_pwm_dac.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/team_06_pwm_pkg.sv
// Shared types and constants for the team_06 PWM audio DAC.
package team_06_pwm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int PWM_BITS_DEF = 8;

  // Silence level for an unsigned, midscale-centred sample of the given width.
  function automatic int midscale(input int bits);
    return 1 << (bits - 1);
  endfunction

endpackage

// File: rtl/team_06_pwm_counter.sv
// Free-running PWM period counter: counts while running, parks at zero when idle,
// and flags the last cycle of each period.
module team_06_pwm_counter #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic [PWM_BITS-1:0] cnt,
  output logic                wrap
);

  always_ff @(posedge clk) begin
    if (rst || !run) cnt <= '0;
    else             cnt <= cnt + PWM_BITS'(1);
  end

  assign wrap = run && (cnt == '1);

endmodule

// File: rtl/team_06_pwm_dac.sv
// PWM audio DAC: holds the latest sample, reloads duty at each period boundary,
// drives the PWM pin. Optional mute ramp on stop/dropout: `define PWM_MUTE_RAMP_EN.
module team_06_pwm_dac
  import team_06_pwm_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] audio_in,
  input  logic                audio_valid,
  input  logic                enable,
  input  logic                clear_underrun,
  output logic                pwm_out,
  output logic                sample_tick,
  output logic                underrun,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] MID = PWM_BITS'(midscale(PWM_BITS));

  state_t              state, state_d;
  logic [PWM_BITS-1:0] cnt, duty, duty_d, hold, settle;
  logic                seen, run, boundary, ur_set, drain_done;

  assign run = (state != IDLE);

  team_06_pwm_counter #(.PWM_BITS(PWM_BITS)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .cnt  (cnt),
    .wrap (boundary)
  );

  // Duty value used when there is no fresh sample: either snap to silence or
  // walk one LSB toward it per period to avoid an audible step.
`ifdef PWM_MUTE_RAMP_EN
  always_comb begin
    settle = duty;
    if (duty > MID)      settle = duty - PWM_BITS'(1);
    else if (duty < MID) settle = duty + PWM_BITS'(1);
  end
  assign drain_done = (settle == MID);
`else
  assign settle     = MID;
  assign drain_done = 1'b1;
`endif

  always_comb begin
    state_d = state;
    duty_d  = duty;
    ur_set  = 1'b0;
    case (state)
      IDLE: begin
        duty_d = MID;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (boundary) begin
          // Same-cycle sample beats the held one: it is the latest.
          if (audio_valid)  duty_d = audio_in;
          else if (seen)    duty_d = hold;
          else begin
            duty_d = settle;
            ur_set = 1'b1;
          end
        end
        if (!enable) state_d = DRAIN;
      end
      DRAIN: begin
        if (boundary) duty_d = settle;
        if (enable)                        state_d = RUN;
        else if (boundary && drain_done)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      duty     <= MID;
      hold     <= MID;
      seen     <= 1'b0;
      pwm_out  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state   <= state_d;
      duty    <= duty_d;
      pwm_out <= run && (cnt < duty);
      if (audio_valid) hold <= audio_in;
      if (boundary)         seen <= 1'b0;
      else if (audio_valid) seen <= 1'b1;
      // A new underrun outranks a simultaneous clear.
      if (ur_set)              underrun <= 1'b1;
      else if (clear_underrun) underrun <= 1'b0;
    end
  end

  assign sample_tick = boundary;
  assign busy        = run;

endmodule

// File: tb/tb_team_06_pwm_dac.sv
// Bench for team_06_pwm_dac: vector table per PWM period, hand-written corner
// sequences, and randomized periods checked against a per-period duty model.
module tb_team_06_pwm_dac;

`ifdef PWM_MUTE_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] audio_in = 8'd0;
  logic       audio_valid = 1'b0;
  logic       enable = 1'b0;
  logic       clear_underrun = 1'b0;
  logic       pwm_out, sample_tick, underrun, busy;

  team_06_pwm_dac #(.PWM_BITS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .audio_in       (audio_in),
    .audio_valid    (audio_valid),
    .enable         (enable),
    .clear_underrun (clear_underrun),
    .pwm_out        (pwm_out),
    .sample_tick    (sample_tick),
    .underrun       (underrun),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic t_tick, o_pwm, o_ur, o_busy;

  typedef struct {
    int         mode;
    logic [7:0] a;
    int         exp_hi;
    bit         exp_ur;
  } vec_t;

  vec_t tbl[7];

  int         cur_duty;
  bit         model_ur;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int toward_mid(input int d);
    if (!RAMP)   return 128;
    if (d > 128) return d - 1;
    if (d < 128) return d + 1;
    return 128;
  endfunction

  // One clock: apply inputs, note the combinational tick, then sample the
  // registered outputs just after the edge.
  task automatic cyc(input bit en, input bit v, input logic [7:0] a, input bit clr);
    enable = en; audio_valid = v; audio_in = a; clear_underrun = clr;
    t_tick = sample_tick;
    @(posedge clk); #1;
    o_pwm = pwm_out; o_ur = underrun; o_busy = busy;
  endtask

  // mode 0: no valid; 1: fixed sample every cycle; 2: sparse random samples.
  task automatic run_period(input int mode, input logic [7:0] a, input int en_off,
                            input int en_on, input int clr_at, output int hi,
                            output int ticks, output bit tick_last,
                            output bit anyv, output logic [7:0] last);
    bit v; logic [7:0] s; bit en;
    hi = 0; ticks = 0; tick_last = 0; anyv = 0; last = 8'd0;
    for (int i = 0; i < 256; i++) begin
      en = !(i >= en_off && i < en_on);
      case (mode)
        0:       begin v = 1'b0; s = 8'($urandom); end
        1:       begin v = 1'b1; s = a; end
        default: begin v = ($urandom_range(0, 15) == 0); s = 8'($urandom); end
      endcase
      if (v) begin anyv = 1; last = s; end
      cyc(en, v, s, (i == clr_at));
      hi += int'(o_pwm);
      ticks += int'(t_tick);
      if (i == 255) tick_last = t_tick;
    end
  endtask

  task automatic model_period(input string name, input int mode, input logic [7:0] a);
    int hi, ticks; bit tl, anyv; logic [7:0] last;
    run_period(mode, a, 256, 256, -1, hi, ticks, tl, anyv, last);
    check({name, " high"}, hi, cur_duty);
    check({name, " ticks"}, ticks + int'(tl), 2);
    if (anyv) cur_duty = int'(last);
    else begin cur_duty = toward_mid(cur_duty); model_ur = 1; end
    check({name, " underrun"}, int'(o_ur), int'(model_ur));
  endtask

  initial begin
    int hi, ticks, n; bit tl, anyv; logic [7:0] last;

    tbl[0] = '{1, 8'd64,  128, 1'b0};
    tbl[1] = '{1, 8'd0,   64,  1'b0};
    tbl[2] = '{1, 8'd255, 0,   1'b0};
    tbl[3] = '{1, 8'd1,   255, 1'b0};
    tbl[4] = '{0, 8'd0,   1,   1'b1};
    tbl[5] = '{1, 8'd200, RAMP ? 2 : 128, 1'b1};
    tbl[6] = '{1, 8'd200, 200, 1'b1};

    // Reset state
    rst = 1'b1;
    cyc(0, 0, 8'd0, 0);
    cyc(0, 0, 8'd0, 0);
    rst = 1'b0;
    check("rst pwm", int'(pwm_out), 0);
    check("rst tick", int'(sample_tick), 0);
    check("rst underrun", int'(underrun), 0);
    check("rst busy", int'(busy), 0);
    cyc(0, 0, 8'd0, 0);
    check("idle busy", int'(o_busy), 0);

    cyc(1, 0, 8'd0, 0);
    check("start busy", int'(o_busy), 1);

    // Table: one entry per PWM period
    for (int k = 0; k < 7; k++) begin
      run_period(tbl[k].mode, tbl[k].a, 256, 256, -1, hi, ticks, tl, anyv, last);
      check($sformatf("tbl%0d high", k), hi, tbl[k].exp_hi);
      check($sformatf("tbl%0d ticks", k), ticks, 1);
      check($sformatf("tbl%0d tick_last", k), int'(tl), 1);
      check($sformatf("tbl%0d underrun", k), int'(o_ur), int'(tbl[k].exp_ur));
    end

    // Clear coinciding with a new underrun: set wins
    run_period(0, 8'd0, 256, 256, 255, hi, ticks, tl, anyv, last);
    check("clr_same high", hi, 200);
    check("clr_same underrun", int'(o_ur), 1);
    // Isolated clear
    run_period(1, 8'd138, 256, 256, 10, hi, ticks, tl, anyv, last);
    check("clr_iso high", hi, RAMP ? 199 : 128);
    check("clr_iso underrun", int'(o_ur), 0);

    // Drain: enable dropped at cnt=100 with duty 138
    run_period(1, 8'd138, 100, 256, -1, hi, ticks, tl, anyv, last);
    check("drain0 high", hi, 138);
    check("drain0 tick_last", int'(tl), 1);
    n = 1;
    while (o_busy && n < 20) begin
      run_period(0, 8'd0, 0, 256, -1, hi, ticks, tl, anyv, last);
      check($sformatf("drain%0d high", n), hi, 138 - n);
      n++;
    end
    check("drain boundaries", n, RAMP ? 10 : 1);
    check("drain busy", int'(o_busy), 0);
    check("drain underrun", int'(o_ur), 0);
    cyc(0, 0, 8'd0, 0);
    check("idle pwm", int'(o_pwm), 0);
    check("idle busy2", int'(o_busy), 0);

    // Re-enable in DRAIN: counter continues, boundary still at cnt=255
    cyc(1, 0, 8'd0, 0);
    run_period(1, 8'd90, 256, 256, -1, hi, ticks, tl, anyv, last);
    check("reen0 high", hi, 128);
    run_period(1, 8'd30, 100, 200, -1, hi, ticks, tl, anyv, last);
    check("reen1 high", hi, 90);
    check("reen1 ticks", ticks, 1);
    check("reen1 tick_last", int'(tl), 1);
    check("reen1 busy", int'(o_busy), 1);
    run_period(1, 8'd30, 256, 256, -1, hi, ticks, tl, anyv, last);
    check("reen2 high", hi, 30);

    // Randomized periods against the duty model
    cur_duty = 30;
    model_ur = 0;
    for (int k = 0; k < 16; k++) begin
      int m;
      m = $urandom_range(0, 3);
      model_period($sformatf("rnd%0d", k), (m == 3) ? 2 : m, 8'($urandom));
    end
    model_period("pre_rst_gap", 0, 8'd0);
    model_period("pre_rst_load", 1, 8'd200);

    // Reset mid-period at cnt=77 with duty 200
    for (int i = 0; i < 77; i++) cyc(1, 1, 8'd200, 0);
    check("pre_rst pwm", int'(o_pwm), 1);
    check("pre_rst underrun", int'(o_ur), 1);
    rst = 1'b1;
    cyc(1, 1, 8'd200, 0);
    rst = 1'b0;
    check("mid_rst pwm", int'(o_pwm), 0);
    check("mid_rst tick", int'(sample_tick), 0);
    check("mid_rst underrun", int'(o_ur), 0);
    check("mid_rst busy", int'(o_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
